// File: rtl/im_program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// master = loader side, slave = stream source / memory side.
interface im_program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BYTE_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BYTE_WIDTH-1:0] in_data;
  logic                  im_wr;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [DATA_WIDTH-1:0] im_w_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, im_wr, im_addr, im_w_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, im_wr, im_addr, im_w_data
  );
endinterface

// File: rtl/im_program_loader.sv
// Boot loader: streams a program into instruction memory, starts the CPU, waits for stop.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module im_program_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  output logic                cpu_start,
  input  logic                cpu_stop,
  output logic                busy,
  output logic                done,
  output logic                err,
  im_program_loader_if.master bus
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_HDR   = 4'd1;
  localparam logic [3:0] S_HI    = 4'd2;
  localparam logic [3:0] S_LO    = 4'd3;
  localparam logic [3:0] S_START = 4'd4;
  localparam logic [3:0] S_RUN   = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd6;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [3:0] S_CHK   = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;
`endif

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [BYTE_WIDTH-1:0] hi_q, hi_d;
  logic                  ready_q, ready_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer;
  logic                  last_word;

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] csum_q, csum_d;
  logic                  err_q, err_d;
`endif

  assign xfer      = bus.in_valid && ready_q;
  // N = 0 encodes a full memory: n_q - 1 is then all-ones, so the last word is at the top address.
  assign last_word = (cnt_q == n_q - ADDR_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    hi_d    = hi_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_req) state_d = S_HDR;
      end
      S_HDR: begin
        if (xfer) begin
          n_d     = ADDR_WIDTH'(bus.in_data);
          cnt_d   = '0;
          state_d = S_HI;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = bus.in_data;
`endif
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d    = bus.in_data;
          state_d = S_LO;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.in_data;
`endif
        end
      end
      S_LO: begin
        if (xfer) begin
          wr_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = {hi_q, bus.in_data};
          cnt_d   = cnt_q + ADDR_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.in_data;
          state_d = last_word ? S_CHK : S_HI;
`else
          state_d = last_word ? S_START : S_HI;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (bus.in_data == csum_q) ? S_START : S_ERR;
      end
      S_ERR: begin
        if (load_req) state_d = S_HDR;
      end
`endif
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (cpu_stop) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered decodes of the next state; cpu_start lags START by one
  // cycle so it never overlaps the final memory write.
  always_comb begin
    ready_d = (state_d == S_HDR) || (state_d == S_HI) || (state_d == S_LO);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
`ifdef LOADER_CHECKSUM_EN
    ready_d = ready_d || (state_d == S_CHK);
    busy_d  = busy_d && (state_d != S_ERR);
    err_d   = (state_d == S_ERR);
`endif
    done_d  = (state_d == S_DONE);
    start_d = (state_q == S_START);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      hi_q    <= '0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      hi_q    <= hi_d;
      ready_q <= ready_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.in_ready  = ready_q;
  assign bus.im_wr     = wr_q;
  assign bus.im_addr   = addr_q;
  assign bus.im_w_data = wdata_q;
  assign cpu_start     = start_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_im_program_loader.sv
// Self-checking bench for im_program_loader: randomized byte-stream loads against a
// word-list / XOR-checksum reference model and a write scoreboard.
module tb_im_program_loader;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_req = 1'b0;
  logic cpu_stop = 1'b0;
  logic cpu_start, busy, done, err;

  im_program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();

  im_program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .cpu_start (cpu_start),
    .cpu_stop  (cpu_stop),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: expected writes in order, plus start/write counters.
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  logic [DW-1:0] prog[256];
  int unsigned   start_cnt = 0;
  int unsigned   wr_cnt = 0;
  bit            byte_pending = 1'b0;
  bit            lo_pending = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (byte_pending) begin
        check(lo_pending ? "wr_after_lo" : "no_wr_after_byte", {31'b0, bus.im_wr}, {31'b0, lo_pending});
        byte_pending = 1'b0;
      end
      if (bus.im_wr === 1'b1) begin
        wr_cnt++;
        if (exp_addr.size() == 0) begin
          check("extra_write", {31'b0, bus.im_wr}, 32'd0);
        end else begin
          check("wr_addr", {24'b0, bus.im_addr}, {24'b0, exp_addr.pop_front()});
          check("wr_data", {16'b0, bus.im_w_data}, {16'b0, exp_data.pop_front()});
        end
      end
      if (cpu_start === 1'b1) begin
        start_cnt++;
        check("start_overlaps_wr", {31'b0, bus.im_wr}, 32'd0);
        check("start_before_writes", exp_addr.size(), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned gap_for(input int unsigned mode);
    case (mode)
      0:       return 0;
      1:       return 1;
      default: return $urandom_range(0, 2);
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b, input int unsigned gap, input bit is_lo);
    bit taken;
    int unsigned guard;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    taken = 1'b0;
    guard = 0;
    while (!taken && guard < 64) begin
      @(negedge clk);
      taken = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    if (!taken) check("handshake_timeout", {31'b0, bus.in_ready}, 32'd1);
    else begin
      check("busy_during_load", {31'b0, busy}, 32'd1);
      byte_pending = 1'b1;
      lo_pending   = is_lo;
    end
  endtask

  // Full load of prog[0..n-1]; n = 256 is sent as header 0.
  task automatic run_load(input int unsigned n, input int unsigned mode, input logic [7:0] csum_xor);
    int unsigned st0 = start_cnt;
    int unsigned w0  = wr_cnt;
    logic [7:0]  hdr = 8'(n);
    logic [7:0]  cs;
    bit          exp_start = 1'b1;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("busy_after_req", {31'b0, busy}, 32'd1);
    check("done_cleared", {31'b0, done}, 32'd0);
    check("err_cleared", {31'b0, err}, 32'd0);
    for (int i = 0; i < int'(n); i++) begin
      exp_addr.push_back(AW'(i));
      exp_data.push_back(prog[i]);
    end
    if (mode == 2) cpu_stop = 1'b1;
    cs = hdr;
    send_byte(hdr, gap_for(mode), 1'b0);
    for (int i = 0; i < int'(n); i++) begin
      logic [15:0] w = prog[i];
      cs = cs ^ w[15:8] ^ w[7:0];
      send_byte(w[15:8], gap_for(mode), 1'b0);
      send_byte(w[7:0], gap_for(mode), 1'b1);
    end
`ifdef LOADER_CHECKSUM_EN
    exp_start = (csum_xor == 8'h00);
    send_byte(cs ^ csum_xor, gap_for(mode), 1'b0);
`else
    if (csum_xor != 8'h00) exp_start = 1'b1;
`endif
    cpu_stop = 1'b0;
    for (int g = 0; g < 20 && exp_start && start_cnt == st0; g++) tick();
    repeat (3) tick();
    check("start_count", start_cnt - st0, exp_start ? 32'd1 : 32'd0);
    check("write_count", wr_cnt - w0, n);
    check("writes_drained", exp_addr.size(), 32'd0);
    check("ready_after_load", {31'b0, bus.in_ready}, 32'd0);
    check("done_in_run", {31'b0, done}, 32'd0);
    check("busy_after_load", {31'b0, busy}, {31'b0, exp_start});
    check("err_after_load", {31'b0, err}, {31'b0, !exp_start});
  endtask

  task automatic stop_cpu();
    cpu_stop = 1'b1;
    tick();
    cpu_stop = 1'b0;
    check("done_on_stop", {31'b0, done}, 32'd1);
    check("busy_on_stop", {31'b0, busy}, 32'd0);
    repeat (4) begin
      cpu_stop = 1'($urandom);
      tick();
    end
    cpu_stop = 1'b0;
    check("done_held", {31'b0, done}, 32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) tick();
    check("rst_im_wr", {31'b0, bus.im_wr}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;
    cpu_stop = 1'b1;
    tick();
    cpu_stop = 1'b0;
    tick();
    check("idle_stop_ignored", {31'b0, done}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);

    // 1: three words, valid held high
    prog[0] = 16'h1234; prog[1] = 16'hABCD; prog[2] = 16'h0001;
    run_load(3, 0, 8'h00);
    stop_cpu();

    // 2: same stream, valid toggling; then load_req during RUN and simultaneous req+stop
    run_load(3, 1, 8'h00);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    repeat (2) tick();
    check("run_req_busy", {31'b0, busy}, 32'd1);
    check("run_req_ready", {31'b0, bus.in_ready}, 32'd0);
    load_req = 1'b1;
    cpu_stop = 1'b1;
    tick();
    load_req = 1'b0;
    cpu_stop = 1'b0;
    check("req_stop_done", {31'b0, done}, 32'd1);
    check("req_stop_busy", {31'b0, busy}, 32'd0);
    check("req_stop_ready", {31'b0, bus.in_ready}, 32'd0);

    // 3: full memory, header 0
    for (int i = 0; i < 256; i++) prog[i] = 16'(i);
    run_load(256, 2, 8'h00);
    stop_cpu();

    // 4: reset during LO of word 2
    prog[0] = 16'h1111; prog[1] = 16'hBEEF; prog[2] = 16'h7777;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    exp_addr.push_back(AW'(0)); exp_data.push_back(prog[0]);
    exp_addr.push_back(AW'(1)); exp_data.push_back(prog[1]);
    send_byte(8'd3, 0, 1'b0);
    send_byte(prog[0][15:8], 0, 1'b0);
    send_byte(prog[0][7:0], 0, 1'b1);
    send_byte(prog[1][15:8], 1, 1'b0);
    send_byte(prog[1][7:0], 0, 1'b1);
    send_byte(prog[2][15:8], 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = prog[2][7:0];
    #2;
    rst = 1'b0;
    byte_pending = 1'b0;
    #1;
    check("async_rst_wr", {31'b0, bus.im_wr}, 32'd0);
    check("async_rst_addr", {24'b0, bus.im_addr}, 32'd0);
    check("async_rst_data", {16'b0, bus.im_w_data}, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_ready", {31'b0, bus.in_ready}, 32'd0);
    check("rst_writes_seen", exp_addr.size(), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    prog[0] = 16'h5555;
    run_load(1, 0, 8'h00);
    stop_cpu();

    // randomized loads
    for (int r = 0; r < 6; r++) begin
      int unsigned n = $urandom_range(1, 24);
      for (int i = 0; i < int'(n); i++) prog[i] = 16'($urandom);
      run_load(n, 2, 8'h00);
      stop_cpu();
    end

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum mismatch (sends 00 instead of 27), then a good checksum
    prog[0] = 16'h1234;
    run_load(1, 0, 8'h27);
    repeat (3) tick();
    check("err_held", {31'b0, err}, 32'd1);
    run_load(1, 0, 8'h00);
    stop_cpu();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
